// File: rtl/seven_segment_reader.sv
// Seven-segment bus reader: recovers the four hex digits driven onto a
// multiplexed active-low anode/segment bus by debouncing each pattern.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   anode[3:0]      digit select, active-low (bit k = digit k)
//   segment[6:0]    {g,f,e,d,c,b,a}, active-low
//   dp              decimal point, active-low
//   digits[15:0]    captured nibbles, digits[4k+3:4k] = digit k
//   digit_valid[3:0] digit k holds a legally decoded value
//   dp_digits[3:0]  captured decimal points, active-high
//   frame_done      pulse when all four positions have been sampled
//   decode_error    pulse on an illegal sampled pattern
//   timeout         pulse when no good sample arrived for TIMEOUT_CYCLES
//   error_count[7:0] saturating count of decode_error pulses
//
// Build option: define SEVEN_SEGMENT_READER_DP_EN to capture dp per digit.
// Without it dp is ignored entirely and dp_digits reads 4'b0000.
module seven_segment_reader #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic [6:0]  segment,
  input  logic        dp,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  dp_digits,
  output logic        frame_done,
  output logic        decode_error,
  output logic        timeout,
  output logic [7:0]  error_count
);

  localparam logic [7:0]  HOLD_LIM = 8'(STABLE_CYCLES);
  localparam logic [23:0] TO_LIM   = 24'(TIMEOUT_CYCLES);

`ifdef SEVEN_SEGMENT_READER_DP_EN
  localparam int PW = 12;
`else
  localparam int PW = 11;
`endif

  // Active-low segment patterns for 0-F; returns {legal, nibble}.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    r = 5'b0_0000;
    unique case (s)
      7'h40:   r = 5'h10;
      7'h79:   r = 5'h11;
      7'h24:   r = 5'h12;
      7'h30:   r = 5'h13;
      7'h19:   r = 5'h14;
      7'h12:   r = 5'h15;
      7'h02:   r = 5'h16;
      7'h78:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h10:   r = 5'h19;
      7'h08:   r = 5'h1A;
      7'h03:   r = 5'h1B;
      7'h46:   r = 5'h1C;
      7'h21:   r = 5'h1D;
      7'h06:   r = 5'h1E;
      7'h0E:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Input capture stage
  logic [3:0]    anode_q;
  logic [6:0]    seg_q;
  logic [PW-1:0] pat;
  logic [PW-1:0] prev_q;

`ifdef SEVEN_SEGMENT_READER_DP_EN
  logic dp_q;
  assign pat = {anode_q, seg_q, dp_q};
`else
  logic dp_unused;
  assign dp_unused = dp;
  assign pat = {anode_q, seg_q};
`endif

  localparam logic [PW-1:0] PAT_BLANK = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      anode_q <= 4'hF;
      seg_q   <= 7'h7F;
      prev_q  <= PAT_BLANK;
`ifdef SEVEN_SEGMENT_READER_DP_EN
      dp_q    <= 1'b1;
`endif
    end else begin
      anode_q <= anode;
      seg_q   <= segment;
      prev_q  <= pat;
`ifdef SEVEN_SEGMENT_READER_DP_EN
      dp_q    <= dp;
`endif
    end
  end

  // Hold counter: the sample fires only on the edge the
  // count first reaches the limit, so a held pattern is
  // sampled exactly once.
  logic [7:0] hold_q, hold_d;
  logic       fire;

  always_comb begin
    hold_d = hold_q;
    if (pat != prev_q) begin
      hold_d = 8'd1;
    end else if (hold_q != HOLD_LIM) begin
      hold_d = hold_q + 8'd1;
    end
  end

  assign fire = (hold_d == HOLD_LIM) && (hold_q != HOLD_LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= 8'd0;
    end else begin
      hold_q <= hold_d;
    end
  end

  // Sample classification
  logic [3:0] sel;
  logic       blank;
  logic       one_sel;
  logic [4:0] dec;

  assign sel     = ~anode_q;
  assign blank   = (sel == 4'b0000);
  assign one_sel = !blank && ((sel & (sel - 4'd1)) == 4'b0000);
  assign dec     = seg_decode(seg_q);

  // Capture state
  logic [15:0] digits_q, digits_d;
  logic [3:0]  valid_q, valid_d;
  logic [3:0]  seen_q, seen_d;
  logic [7:0]  err_q, err_d;
  logic [23:0] tcnt_q, tcnt_d;
  logic        frame_q, frame_d;
  logic        derr_q, derr_d;
  logic        tout_q, tout_d;
  logic [3:0]  dpd_q, dpd_d;
  logic        good;

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    seen_d   = seen_q;
    err_d    = err_q;
    tcnt_d   = tcnt_q;
    dpd_d    = dpd_q;
    frame_d  = 1'b0;
    derr_d   = 1'b0;
    tout_d   = 1'b0;
    good     = 1'b0;

    if (fire && !blank) begin
      if (!one_sel) begin
        derr_d = 1'b1;
      end else begin
        seen_d = seen_q | sel;
`ifdef SEVEN_SEGMENT_READER_DP_EN
        dpd_d = (dpd_q & ~sel) | ({4{~dp_q}} & sel);
`endif
        if (dec[4]) begin
          for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
              digits_d[4*i +: 4] = dec[3:0];
            end
          end
          valid_d = valid_q | sel;
          good    = 1'b1;
        end else begin
          valid_d = valid_q & ~sel;
          derr_d  = 1'b1;
        end
        if (seen_d == 4'hF) begin
          frame_d = 1'b1;
          seen_d  = 4'h0;
        end
      end
    end

    if (derr_d && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end

    // A good sample restarts the watchdog and so always
    // wins over an expiry on the same edge.
    if (good) begin
      tcnt_d = 24'd0;
    end else if (tcnt_q + 24'd1 == TO_LIM) begin
      tout_d  = 1'b1;
      valid_d = 4'h0;
      seen_d  = 4'h0;
      tcnt_d  = 24'd0;
    end else begin
      tcnt_d = tcnt_q + 24'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digits_q <= 16'h0000;
      valid_q  <= 4'h0;
      seen_q   <= 4'h0;
      err_q    <= 8'h00;
      tcnt_q   <= 24'd0;
      dpd_q    <= 4'h0;
      frame_q  <= 1'b0;
      derr_q   <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      digits_q <= digits_d;
      valid_q  <= valid_d;
      seen_q   <= seen_d;
      err_q    <= err_d;
      tcnt_q   <= tcnt_d;
      dpd_q    <= dpd_d;
      frame_q  <= frame_d;
      derr_q   <= derr_d;
      tout_q   <= tout_d;
    end
  end

  assign digits       = digits_q;
  assign digit_valid  = valid_q;
  assign frame_done   = frame_q;
  assign decode_error = derr_q;
  assign timeout      = tout_q;
  assign error_count  = err_q;

`ifdef SEVEN_SEGMENT_READER_DP_EN
  assign dp_digits = dpd_q;
`else
  logic [3:0] dpd_unused;
  assign dpd_unused = dpd_q;
  assign dp_digits  = 4'b0000;
`endif

endmodule

// File: tb/tb_seven_segment_reader.sv
// Randomized bench for seven_segment_reader against a
// history-based reference model.
module tb_seven_segment_reader;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  anode;
  logic [6:0]  segment;
  logic        dp;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic [3:0]  dp_digits;
  logic        frame_done;
  logic        decode_error;
  logic        timeout;
  logic [7:0]  error_count;

  seven_segment_reader #(
    .STABLE_CYCLES (STABLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .anode       (anode),
    .segment     (segment),
    .dp          (dp),
    .digits      (digits),
    .digit_valid (digit_valid),
    .dp_digits   (dp_digits),
    .frame_done  (frame_done),
    .decode_error(decode_error),
    .timeout     (timeout),
    .error_count (error_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Active-low hex font, index = value
  logic [6:0] font [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Reference model state
  logic [11:0] hist[$];
  int          m_dig[4];
  logic [3:0]  m_valid;
  logic [3:0]  m_dp;
  logic [3:0]  m_seen;
  int          m_err;
  int          m_tc;
  logic        e_fd, e_de, e_to;
  int          n_fd, n_to, n_de;

  function automatic logic [11:0] cur_pat();
`ifdef SEVEN_SEGMENT_READER_DP_EN
    return {anode, segment, dp};
`else
    return {anode, segment, 1'b1};
`endif
  endfunction

  task automatic model_reset();
    hist.delete();
    hist.push_back(12'hFFF);
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
    m_valid = 0; m_dp = 0; m_seen = 0;
    m_err = 0; m_tc = 0;
    e_fd = 0; e_de = 0; e_to = 0;
  endtask

  // Sample when the pattern seen by the reader has been
  // constant for exactly STABLE captured cycles.
  task automatic model_edge();
    int r, k, nlow, idx;
    logic [11:0] v;
    logic [3:0] a;
    logic good;
    if (reset) begin
      model_reset();
      return;
    end
    r = 0;
    v = hist[$];
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == v) r++;
      else break;
    end
    e_fd = 0; e_de = 0; e_to = 0; good = 0;
    a = v[11:8];
    if (r == STABLE && a != 4'hF) begin
      nlow = 0; k = 0;
      for (int i = 0; i < 4; i++)
        if (!a[i]) begin nlow++; k = i; end
      if (nlow != 1) begin
        e_de = 1;
      end else begin
        idx = -1;
        for (int j = 0; j < 16; j++)
          if (font[j] == v[7:1]) idx = j;
        m_seen[k] = 1'b1;
`ifdef SEVEN_SEGMENT_READER_DP_EN
        m_dp[k] = ~v[0];
`endif
        if (idx >= 0) begin
          m_dig[k] = idx;
          m_valid[k] = 1'b1;
          good = 1;
        end else begin
          m_valid[k] = 1'b0;
          e_de = 1;
        end
        if (m_seen == 4'hF) begin
          e_fd = 1;
          m_seen = 0;
        end
      end
    end
    if (e_de && m_err < 255) m_err++;
    if (good) begin
      m_tc = 0;
    end else begin
      m_tc++;
      if (m_tc == TIMEOUT) begin
        e_to = 1; m_valid = 0; m_seen = 0; m_tc = 0;
      end
    end
    hist.push_back(cur_pat());
    if (hist.size() > STABLE + 1) void'(hist.pop_front());
  endtask

  task automatic step();
    logic [15:0] ed;
    @(posedge clk);
    #1;
    model_edge();
    ed = {m_dig[3][3:0], m_dig[2][3:0], m_dig[1][3:0], m_dig[0][3:0]};
    check("digits", digits, ed);
    check("valid", digit_valid, m_valid);
    check("dp", dp_digits, m_dp);
    check("frame", frame_done, e_fd);
    check("derr", decode_error, e_de);
    check("tout", timeout, e_to);
    check("errcnt", error_count, m_err);
    n_fd += frame_done;
    n_to += timeout;
    n_de += decode_error;
  endtask

  task automatic hold(logic [3:0] a, logic [6:0] s,
                      logic d, int n);
    anode = a; segment = s; dp = d;
    repeat (n) step();
  endtask

  logic [3:0] anodes [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    reset = 1; anode = 4'hF; segment = 7'h7F; dp = 1;
    model_reset();
    n_fd = 0; n_to = 0; n_de = 0;
    step(); step();
    check("rst_digits", digits, 16'h0000);
    check("rst_errcnt", error_count, 8'h00);
    reset = 0;

    // Single digit '2' on position 0
    hold(4'b1110, 7'h24, 1, 4);
    check("d2_early", digit_valid, 4'b0000);
    step();
    check("d2_val", digits[3:0], 4'h2);
    check("d2_valid", digit_valid, 4'b0001);

    // Scan 3, A, 0, F
    n_fd = 0; n_de = 0;
    hold(4'b1110, 7'h30, 0, 6);
    hold(4'b1101, 7'h08, 1, 6);
    hold(4'b1011, 7'h40, 0, 6);
    hold(4'b0111, 7'h0E, 1, 6);
    check("scan_digits", digits, 16'hF0A3);
    check("scan_valid", digit_valid, 4'b1111);
    check("scan_frames", n_fd, 1);
    check("scan_noerr", n_de, 0);

    // Too-short hold
    hold(4'b1110, 7'h79, 1, 3);
    hold(4'hF, 7'h7F, 1, 2);
    check("short_digits", digits, 16'hF0A3);

    // Blank segments, then two anodes low
    hold(4'b1101, 7'h7F, 1, 6);
    check("bad_seg_valid1", digit_valid[1], 1'b0);
    check("bad_seg_cnt", error_count, 8'd1);
    hold(4'b1100, 7'h40, 1, 6);
    check("multi_cnt", error_count, 8'd2);

    // Timeout after a capture
    hold(4'b1110, 7'h24, 1, 5);
    n_to = 0;
    hold(4'hF, 7'h7F, 1, 16);
    check("to_pulses", n_to, 1);
    check("to_valid", digit_valid, 4'b0000);
    check("to_keep", digits[3:0], 4'h2);

    // Reset on the third cycle of a hold
    hold(4'b1011, 7'h30, 1, 2);
    reset = 1;
    step();
    reset = 0;
    check("mid_rst_digits", digits, 16'h0000);
    check("mid_rst_valid", digit_valid, 4'b0000);
    repeat (4) step();
    check("mid_rst_wait", digit_valid, 4'b0000);
    step();
    check("mid_rst_sample", digit_valid, 4'b0100);
    check("mid_rst_val", digits[11:8], 4'h3);

    // Drive the error counter into saturation
    for (int i = 0; i < 130; i++) begin
      hold(4'b1100, 7'h40, 1, 5);
      hold(4'b1010, 7'h40, 1, 5);
    end
    check("sat_cnt", error_count, 8'hFF);

    // Random bus traffic
    for (int i = 0; i < 500; i++) begin
      logic [3:0] a;
      logic [6:0] s;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 7) a = anodes[$urandom_range(0, 3)];
      else if (sel == 7) a = 4'hF;
      else a = 4'($urandom);
      if ($urandom_range(0, 4) != 0) s = font[$urandom_range(0, 15)];
      else s = 7'($urandom);
      if ($urandom_range(0, 60) == 0) begin
        reset = 1;
        step();
        reset = 0;
      end
      hold(a, s, 1'($urandom), int'($urandom_range(1, 8)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_segment_reader.md
SEVEN_SEGMENT_READER -- requirements
Module: seven_segment_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive cycles an input pattern must hold before it is sampled; legal range 2..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 65535: cycles without a successful sample before all captured digits are invalidated; legal range 16..2^24-1.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 anode  input  4  digit select, active-low; bit k selects digit k.
REQ-006 segment  input  7  segments {g,f,e,d,c,b,a}, active-low, same encoding as the seven_segment decoder.
REQ-007 dp  input  1  decimal point, active-low.
REQ-008 digits  output  16  captured nibbles; digits[4k+3:4k] is digit k.
REQ-009 digit_valid  output  4  bit k=1 when digit k holds a legally decoded value.
REQ-010 dp_digits  output  4  captured decimal point per digit, active-high.
REQ-011 frame_done  output  1  one-cycle pulse when all four positions have been sampled since the last frame_done.
REQ-012 decode_error  output  1  one-cycle pulse on an illegal sampled pattern.
REQ-013 timeout  output  1  one-cycle pulse on timeout expiry.
REQ-014 error_count  output  8  saturating count of decode_error pulses.

Function
REQ-015 anode and {segment, dp} SHALL be registered once before any other use.
REQ-016 Hold counter: increments while the registered {anode,segment,dp} equals its value on the previous cycle; reloads to 1 on any change; saturates at STABLE_CYCLES.
REQ-017 Exactly one sample per hold: on the edge where the counter reaches STABLE_CYCLES; no resample until the pattern changes. Output update is visible STABLE_CYCLES+1 edges after the input change.
REQ-018 anode=4'b1111 (blanked) SHALL never be sampled and SHALL not count as an error.
REQ-019 anode with more than one low bit at sample time: decode_error pulses, no digit state changes.
REQ-020 segment not one of the 16 hex patterns (0-F) at sample time with one-hot-low anode k: decode_error pulses, digit_valid[k] cleared, digit k nibble unchanged, position k marked seen.
REQ-021 Legal pattern with anode k: digit k nibble loaded with the decoded value, digit_valid[k] set, position k marked seen.
REQ-022 When the seen mask becomes 4'b1111, frame_done pulses in the same cycle as the completing update and the seen mask clears; repeated samples of one position do not advance the frame.
REQ-023 error_count increments by 1 per decode_error and holds at 8'hFF.
REQ-024 Timeout counter clears on every successful sample (REQ-021), otherwise increments; on reaching TIMEOUT_CYCLES: timeout pulses, digit_valid clears to 4'b0000, seen mask clears, counter reloads to 0. digits is retained.
REQ-025 When a sample and timeout expiry coincide, the sample takes priority and timeout does not pulse.

Reset
REQ-026 reset SHALL force digits=16'h0000, digit_valid=4'b0000, dp_digits=4'b0000, frame_done=0, decode_error=0, timeout=0, error_count=8'h00, and clear the hold counter, timeout counter, seen mask and input registers to blanked (anode=4'b1111).
REQ-027 reset asserted mid-hold SHALL discard the partial hold; after release a full STABLE_CYCLES hold is required to sample.

Configuration
REQ-028 SEVEN_SEGMENT_READER_DP_EN defined: dp_digits[k] loads ~dp on every sample of digit k, legal or not.
REQ-029 SEVEN_SEGMENT_READER_DP_EN undefined: dp is ignored, including for change detection in REQ-016, and dp_digits is tied to 4'b0000.

Verification
REQ-030 anode=4'b1110, segment=7'b0100100 held 5 cycles -> digits[3:0]=4'h2, digit_valid=4'b0001 after edge 5, no error.
REQ-031 Scan digits 0..3 with 3, A, 0, F, each held 6 cycles -> digits=16'hF0A3, digit_valid=4'b1111, exactly one frame_done pulse.
REQ-032 Pattern held 3 cycles then changed, STABLE_CYCLES=4 -> no output change.
REQ-033 anode=4'b1101, segment=7'b1111111 held -> one decode_error pulse, digit_valid[1]=0, error_count=1. anode=4'b1100 held -> second pulse, error_count=2.
REQ-034 TIMEOUT_CYCLES=16, valid digits captured then anode=4'b1111 for 16 cycles -> one timeout pulse, digit_valid=4'b0000, digits unchanged.
REQ-035 reset asserted on cycle 3 of a 4-cycle hold -> all outputs at reset values, no sample until 4 further stable cycles.
